data_mem_wt: RTL and testbench
==============================

Name: data_mem_wt

Overview:
Data-side memory stage directly downstream of the pipelined core's data port (data_w / data_addr / data_out / data_in). It holds a local word-addressed data RAM that serves loads with zero latency, as the core's second stage requires. Every store is also pushed into a small write-through queue that drains to an external bus over a valid/ready handshake.

Parameters:
ADDR_W, 8, word-address bits used to index the local RAM; depth = 2**ADDR_W words
Q_DEPTH, 4, write-through queue entries; power of 2, at least 2
DATA_W, 32, data word width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
w_en  in  1  store strobe from the core (core data_w)
addr  in  32  word address from the core (core data_addr); only addr[ADDR_W-1:0] is used
wdata  in  DATA_W  store data from the core (core data_out)
rdata  out  DATA_W  load data to the core (core data_in)
ext_valid  out  1  queue head is valid on the external bus
ext_ready  in  1  external bus accepts the head
ext_addr  out  32  queued store address (full 32 bits as issued)
ext_data  out  DATA_W  queued store data
q_count  out  $clog2(Q_DEPTH)+1  current queue occupancy
overflow  out  1  sticky: a store was dropped from the queue

Behaviour:
- Reset (async assert, sync-safe deassert use): queue pointers = 0, q_count = 0, ext_valid = 0, overflow = 0. ext_addr and ext_data read the head slot; their value while ext_valid = 0 does not matter. RAM contents are not reset. Reset asserted mid-drain discards all queued entries and makes no further ext transfers.
- Loads: rdata = ram[addr[ADDR_W-1:0]], combinational (asynchronous read), zero latency. If w_en = 1 to the same address in the same cycle, rdata shows the old contents. The new value is visible from the cycle after the clock edge.
- Stores: when w_en = 1 at a rising edge, ram[addr[ADDR_W-1:0]] <= wdata, unconditionally. This local write happens even if the store overflows the queue.
- Queue push: w_en = 1 pushes {addr, wdata} at the tail.
- Queue pop: ext_valid && ext_ready at a rising edge pops the head. ext_valid = (q_count != 0).
- Head stability: ext_addr and ext_data stay stable while ext_valid = 1 and ext_ready = 0.
- Latency: a store pushed at edge N appears on ext_valid from the cycle after edge N, when the queue was empty. There is no bypass of the queue.
- Simultaneous push and pop: q_count is unchanged. When the queue is full, the pop frees the slot and the push is accepted, so overflow is not set.
- Full without pop: w_en = 1 with q_count = Q_DEPTH and no pop drops the push (RAM is still written). overflow <= 1 and stays set until reset.
- Pointer wrap: read and write pointers are ADDR-free, $clog2(Q_DEPTH) bits, and wrap modulo Q_DEPTH. Full/empty is derived from q_count.
- w_en = 0: no RAM write, no push. rdata still tracks addr.
- No X propagation: ext_valid and q_count are always defined after reset.

Decomposition:
- Shared package: DATA_W default, the queue entry struct {addr[31:0], data[DATA_W-1:0]}, and a Q_DEPTH legality check constant.
- One natural sub-module: sync_fifo (parameterised by width and depth; push/pop/full/empty/count).
- The RAM array and the overflow flag stay in data_mem_wt.

Test Plan:
- Reset, then store 0xDEADBEEF to addr 5 -> rdata at addr 5 reads 0xDEADBEEF on the next cycle; ext_valid = 1, ext_addr = 5, ext_data = 0xDEADBEEF; q_count = 1.
- Same-cycle read and write: addr 7 holds 0x11, store 0x22 to addr 7 -> rdata = 0x11 in that cycle and 0x22 in the next.
- Hold ext_ready = 0 and issue 4 stores (0x1..0x4) -> q_count = 4, head stays 0x1. A 5th store (0x5) sets overflow = 1, RAM still holds 0x5, q_count stays 4. Then ext_ready = 1 -> 0x1..0x4 drain in order, with no 0x5.
- Queue full, store and pop in the same cycle -> q_count stays 4, overflow stays 0; draining then yields the new entry last.
- Back-to-back: ext_ready = 1 with a store every cycle for 20 cycles -> each entry is seen one cycle after its push, q_count <= 1, pointers wrap correctly, order is preserved.
- Assert rst_n = 0 asynchronously with q_count = 3 -> ext_valid = 0 and q_count = 0 immediately. Previously written RAM words keep their values.

Source files
------------

// File: rtl/data_mem_wt_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_wt_pkg
// Shared definitions for the data-side memory stage:
//   DEF_DATA_W  - default data word width
//   q_entry_t   - write-through queue entry {addr, data} at the default width
//   q_depth_ok  - legality rule for the queue depth (power of two, >= 2)
// -----------------------------------------------------------------------------
package data_mem_wt_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int EXT_ADDR_W = 32;

    typedef struct packed {
        logic [EXT_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } q_entry_t;

    function automatic bit q_depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/data_mem_wt_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with combinational head read (show-ahead).
// Ports:
//   clk, rst_n     - clock, async active-low reset (pointers/count only)
//   push, wdata    - write request and data; accepted when not full, or when
//                    a pop frees a slot in the same cycle
//   pop            - read request; ignored while empty
//   rdata          - head entry (meaningless while empty)
//   full, empty    - occupancy flags derived from count
//   count          - current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the head slot, so a push to a full FIFO
    // still lands (wr_ptr == rd_ptr then, and the head is read before the edge).
    assign do_push = push && (!full || do_pop);

    assign rdata = mem[rd_ptr];
    assign count = cnt;

    // NOTE: storage has no reset so it maps onto plain RAM/flops without a
    // reset network; validity is tracked by cnt, never by the contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: sequential state is assigned with <= only, so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            // Pointers are log2(DEPTH) bits wide, so they wrap modulo DEPTH.
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/data_mem_wt.sv
// -----------------------------------------------------------------------------
// data_mem_wt
// Data-side memory stage behind the core's data port. A local word-addressed
// RAM answers loads combinationally; every store updates the RAM and is also
// queued for write-through to an external valid/ready bus.
// Ports:
//   clk, rst_n           - clock, async active-low reset
//   w_en, addr, wdata    - store strobe, word address, store data from core
//   rdata                - load data, ram[addr[ADDR_W-1:0]], zero latency
//   ext_valid/ext_ready  - write-through handshake (head popped on both high)
//   ext_addr, ext_data   - head entry of the write-through queue
//   q_count              - queue occupancy
//   overflow             - sticky: a store found the queue full and was dropped
// -----------------------------------------------------------------------------
module data_mem_wt
    import data_mem_wt_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int Q_DEPTH = 4,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       w_en,
    input  logic [EXT_ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata,
    output logic                       ext_valid,
    input  logic                       ext_ready,
    output logic [EXT_ADDR_W-1:0]      ext_addr,
    output logic [DATA_W-1:0]          ext_data,
    output logic [$clog2(Q_DEPTH):0]   q_count,
    output logic                       overflow
);

    localparam int RAM_DEPTH = 2 ** ADDR_W;

    if (!q_depth_ok(Q_DEPTH)) begin : g_bad_q_depth
        $error("data_mem_wt: Q_DEPTH must be a power of two and at least 2");
    end

    // Queue entry at the instance's data width (the package type covers the
    // default width only).
    typedef struct packed {
        logic [EXT_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } entry_t;

    logic [DATA_W-1:0] ram [RAM_DEPTH];
    entry_t            push_entry;
    entry_t            head_entry;
    logic              q_full;
    logic              q_empty;
    logic              pop_fire;

    // ------------------------------------------------------------------ RAM
    // Asynchronous read: a same-cycle store shows the old word until the edge.
    assign rdata = ram[addr[ADDR_W-1:0]];

    // The local write is unconditional on w_en, even when the queue drops it.
    always_ff @(posedge clk) begin
        if (w_en) begin
            ram[addr[ADDR_W-1:0]] <= wdata;
        end
    end

    // ------------------------------------------------------ write-through queue
    assign push_entry = '{addr: addr, data: wdata};
    assign ext_valid  = !q_empty;
    assign pop_fire   = ext_valid && ext_ready;
    assign ext_addr   = head_entry.addr;
    assign ext_data   = head_entry.data;

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (Q_DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_en),
        .wdata (push_entry),
        .pop   (ext_ready),
        .rdata (head_entry),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    // A store is lost only when the queue is full and no pop frees a slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (w_en && q_full && !pop_fire) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_data_mem_wt.sv
module tb_data_mem_wt;

    localparam int ADDR_W  = 8;
    localparam int Q_DEPTH = 4;
    localparam int DATA_W  = 32;

    logic                     clk;
    logic                     rst_n;
    logic                     w_en;
    logic [31:0]              addr;
    logic [DATA_W-1:0]        wdata;
    logic [DATA_W-1:0]        rdata;
    logic                     ext_valid;
    logic                     ext_ready;
    logic [31:0]              ext_addr;
    logic [DATA_W-1:0]        ext_data;
    logic [$clog2(Q_DEPTH):0] q_count;
    logic                     overflow;

    data_mem_wt #(
        .ADDR_W  (ADDR_W),
        .Q_DEPTH (Q_DEPTH),
        .DATA_W  (DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .w_en      (w_en),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ext_valid (ext_valid),
        .ext_ready (ext_ready),
        .ext_addr  (ext_addr),
        .ext_data  (ext_data),
        .q_count   (q_count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------- reference model
    // Queue of pending stores, RAM image with written-flags, sticky drop flag.
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } qe_t;

    qe_t         mq[$];
    logic [31:0] mram [2**ADDR_W];
    bit          mwritten [2**ADDR_W];
    bit          movf;

    task automatic model_reset();
        mq.delete();
        movf = 1'b0;
    endtask

    // Applies one cycle of inputs, compares pre-edge outputs against the model,
    // then advances the model across the rising edge.
    task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic r, input string tag);
        bit pop;
        int idx;
        @(negedge clk);
        w_en = w; addr = a; wdata = d; ext_ready = r;
        #1;
        idx = int'(a[ADDR_W-1:0]);
        if (mwritten[idx]) check({tag, ".rdata"}, 64'(rdata), 64'(mram[idx]));
        check({tag, ".ext_valid"}, 64'(ext_valid), 64'(mq.size() != 0));
        check({tag, ".q_count"}, 64'(q_count), 64'(mq.size()));
        check({tag, ".overflow"}, 64'(overflow), 64'(movf));
        if (mq.size() != 0) begin
            check({tag, ".ext_addr"}, 64'(ext_addr), 64'(mq[0].a));
            check({tag, ".ext_data"}, 64'(ext_data), 64'(mq[0].d));
        end
        @(posedge clk);
        pop = (mq.size() != 0) && r;
        if (pop) void'(mq.pop_front());
        if (w) begin
            mram[idx] = d;
            mwritten[idx] = 1'b1;
            if (mq.size() < Q_DEPTH) mq.push_back('{a: a, d: d});
            else movf = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; w_en = 1'b0; ext_ready = 1'b0; addr = '0; wdata = '0;
        @(negedge clk);
        #1;
        check("reset.ext_valid", 64'(ext_valid), 64'(0));
        check("reset.q_count", 64'(q_count), 64'(0));
        check("reset.overflow", 64'(overflow), 64'(0));
        rst_n = 1'b1;
        model_reset();
    endtask

    // ------------------------------------------------------ directed vector table
    // Expected values are the pre-edge outputs for the inputs on that row.
    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic        r;
        bit          chk_rd;
        logic [31:0] e_rd;
        logic        e_valid;
        int          e_cnt;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic w, input logic [31:0] a, input logic [31:0] d, input logic r,
                       input bit chk_rd, input logic [31:0] e_rd, input logic e_valid,
                       input int e_cnt, input logic [31:0] e_addr, input logic [31:0] e_data,
                       input logic e_ovf);
        vecs.push_back('{w, a, d, r, chk_rd, e_rd, e_valid, e_cnt, e_addr, e_data, e_ovf});
    endtask

    initial begin
        logic [31:0] ra;
        rst_n = 1'b0; w_en = 1'b0; ext_ready = 1'b0; addr = '0; wdata = '0;
        for (int i = 0; i < 2**ADDR_W; i++) mwritten[i] = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        //   w  addr   wdata         rdy chk rdata         vld cnt head_a  head_d        ovf
        add(1, 5,     32'hDEADBEEF, 0,  0,  0,            0,  0,  0,      0,            0);
        add(0, 5,     0,            0,  1,  32'hDEADBEEF, 1,  1,  5,      32'hDEADBEEF, 0);
        add(1, 7,     32'h11,       1,  0,  0,            1,  1,  5,      32'hDEADBEEF, 0);
        add(1, 7,     32'h22,       1,  1,  32'h11,       1,  1,  7,      32'h11,       0);
        add(0, 7,     0,            1,  1,  32'h22,       1,  1,  7,      32'h22,       0);
        add(0, 7,     0,            0,  1,  32'h22,       0,  0,  0,      0,            0);
        add(1, 16,    32'h1,        0,  0,  0,            0,  0,  0,      0,            0);
        add(1, 17,    32'h2,        0,  0,  0,            1,  1,  16,     32'h1,        0);
        add(1, 18,    32'h3,        0,  0,  0,            1,  2,  16,     32'h1,        0);
        add(1, 19,    32'h4,        0,  0,  0,            1,  3,  16,     32'h1,        0);
        add(1, 20,    32'h5,        0,  0,  0,            1,  4,  16,     32'h1,        0);
        add(0, 20,    0,            0,  1,  32'h5,        1,  4,  16,     32'h1,        1);
        add(0, 20,    0,            1,  1,  32'h5,        1,  4,  16,     32'h1,        1);
        add(0, 20,    0,            1,  0,  0,            1,  3,  17,     32'h2,        1);
        add(0, 20,    0,            1,  0,  0,            1,  2,  18,     32'h3,        1);
        add(0, 20,    0,            1,  0,  0,            1,  1,  19,     32'h4,        1);
        add(0, 20,    0,            0,  0,  0,            0,  0,  0,      0,            1);

        foreach (vecs[i]) begin
            @(negedge clk);
            w_en = vecs[i].w; addr = vecs[i].a; wdata = vecs[i].d; ext_ready = vecs[i].r;
            #1;
            if (vecs[i].chk_rd) check($sformatf("vec%0d.rdata", i), 64'(rdata), 64'(vecs[i].e_rd));
            check($sformatf("vec%0d.ext_valid", i), 64'(ext_valid), 64'(vecs[i].e_valid));
            check($sformatf("vec%0d.q_count", i), 64'(q_count), 64'(vecs[i].e_cnt));
            check($sformatf("vec%0d.overflow", i), 64'(overflow), 64'(vecs[i].e_ovf));
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d.ext_addr", i), 64'(ext_addr), 64'(vecs[i].e_addr));
                check($sformatf("vec%0d.ext_data", i), 64'(ext_data), 64'(vecs[i].e_data));
            end
        end

        // ---------------- full queue: store and pop in the same cycle
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 32'h40 + 32'(i), 32'hA0 + 32'(i), 0, "fill");
        step(1, 32'h44, 32'hA4, 1, "full_pushpop");
        check("full_pushpop.cnt_after", 64'(q_count), 64'(4));
        check("full_pushpop.ovf_after", 64'(overflow), 64'(0));
        for (int i = 0; i < 5; i++) step(0, 32'h44, 0, 1, "full_drain");
        check("full_drain.last_empty", 64'(ext_valid), 64'(0));

        // ---------------- back-to-back stores with ready held high
        for (int i = 0; i < 20; i++) begin
            step(1, 32'h1000_0080 + 32'(i), $urandom, 1, "b2b");
            check("b2b.count_le1", 64'(q_count <= 1), 64'(1));
        end
        step(0, 32'h80, 0, 1, "b2b_tail");

        // ---------------- asynchronous reset mid-drain
        for (int i = 0; i < 3; i++) step(1, 32'h90 + 32'(i), 32'hC0 + 32'(i), 0, "pre_rst");
        @(negedge clk);
        ext_ready = 1'b1; w_en = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst.ext_valid", 64'(ext_valid), 64'(0));
        check("async_rst.q_count", 64'(q_count), 64'(0));
        check("async_rst.overflow", 64'(overflow), 64'(0));
        @(posedge clk);
        #1;
        check("async_rst.no_xfer", 64'(ext_valid), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) step(0, 32'h90 + 32'(i), 0, 0, "post_rst_ram");
        check("post_rst.ram_direct", 64'(rdata), 64'(32'hC2));

        // ---------------- randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            ra = {$urandom_range(0, 255) << 8, 8'($urandom_range(0, 15))};
            step(1'($urandom_range(0, 1)), ra, $urandom, 1'($urandom_range(0, 3) != 0), "rand");
        end
        for (int i = 0; i < Q_DEPTH + 1; i++) step(0, 0, 0, 1, "rand_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
